// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Requests are accepted one at a time, sized by funct3, and answered after WAIT_CYCLES wait states.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    logic             lat_write;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_wdata;
    logic [2:0]       lat_funct3;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             access;
    logic [31:0]      off;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      rd_word;
    logic [31:0]      wr_word;
    logic [31:0]      load_data;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic             bad_range;
    logic             bad_align;
    logic             bad_funct3;
    logic             acc_error;

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign accept    = req_valid && req_ready;
    assign access    = (state == ST_WAIT) && (wait_cnt == 4'd0);

    assign off      = lat_addr - ADDR_BASE;
    assign word_idx = off[IDX_W+1:2];
    assign lane     = off[1:0];
    assign rd_word  = mem[word_idx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    // funct3[1:0] encodes the access size; loads additionally allow the unsigned variants
    always_comb begin
        bad_range = (off >= SPAN);
        bad_align = 1'b0;
        case (lat_funct3[1:0])
            2'b01:   bad_align = lane[0];
            2'b10:   bad_align = (lane != 2'b00);
            default: bad_align = 1'b0;
        endcase
        if (lat_write) begin
            bad_funct3 = lat_funct3[2] || (lat_funct3[1:0] == 2'b11);
        end else begin
            bad_funct3 = (lat_funct3[1:0] == 2'b11) || (lat_funct3 == 3'b110);
        end
        acc_error = bad_range || bad_align || bad_funct3;
    end

    always_comb begin
        load_data = 32'd0;
        case (lat_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase
    end

    // Read-modify-write merge keeps the unaddressed bytes of the word intact
    always_comb begin
        wr_word = rd_word;
        case (lat_funct3[1:0])
            2'b00: wr_word[{lane, 3'b000} +: 8] = lat_wdata[7:0];
            2'b01: begin
                if (lane[1]) begin
                    wr_word[31:16] = lat_wdata[15:0];
                end else begin
                    wr_word[15:0] = lat_wdata[15:0];
                end
            end
            2'b10:   wr_word = lat_wdata;
            default: wr_word = rd_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            wait_cnt   <= 4'd0;
            lat_write  <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_funct3 <= 3'd0;
            rsp_rdata  <= 32'd0;
            rsp_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_write  <= req_write;
                        lat_addr   <= req_addr;
                        lat_wdata  <= req_wdata;
                        lat_funct3 <= req_funct3;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_RESP;
                        rsp_error <= acc_error;
                        rsp_rdata <= (acc_error || lat_write) ? 32'd0 : load_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_rdata <= 32'd0;
                        rsp_error <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage survives reset; a reset during WAIT forces IDLE so the access edge never arrives
    always_ff @(posedge clk) begin
        if (access && lat_write && !acc_error) begin
            mem[word_idx] <= wr_word;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a 2-wait-state instance for the main checks
// and a zero-wait instance for back-to-back throughput.
module tb_dmem_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_write0;
    logic [31:0] req_addr0, req_wdata0;
    logic [2:0]  req_funct30;
    logic        rsp_valid0, rsp_ready0, rsp_error0;
    logic [31:0] rsp_rdata0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          id;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   req_id = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W), .ADDR_BASE(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .ADDR_BASE(32'h0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_funct3(req_funct30),
        .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_rdata(rsp_rdata0), .rsp_error(rsp_error0)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Drive a request, wait for its acceptance edge and record the expected response
    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
        int n = 0;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        req_valid  = 1'b1;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) check_output("accept_timeout", 32'd0, 32'd1);
        tick();
        req_id++;
        sb_q.push_back('{rdata: exp_rdata, err: exp_err, id: req_id});
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        check_output($sformatf("rsp%0d_latency", req_id), lat, W + 1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        if (sb_q.size() != 0) begin
            check_output("drain_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, input logic [31:0] exp_rdata, input logic exp_err);
        send_req(wr, addr, wdata, f3, exp_rdata, exp_err);
        wait_rsp();
        drain();
    endtask

    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                check_output($sformatf("rsp%0d_rdata", sb_e.id), rsp_rdata, sb_e.rdata);
                check_output($sformatf("rsp%0d_error", sb_e.id), {31'd0, rsp_error}, {31'd0, sb_e.err});
            end
        end
    end

    logic [31:0] z_addr  [4] = '{32'h08, 32'h08, 32'h0A, 32'h09};
    logic [31:0] z_exp   [4] = '{32'h0, 32'hA5A5_0F0F, 32'h0000_A5A5, 32'h0000_000F};
    logic [2:0]  z_f3    [4] = '{3'b010, 3'b010, 3'b101, 3'b000};
    logic        z_write [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0; req_funct30 = 3'd0;
        rsp_ready0 = 1'b1;

        repeat (3) tick();
        check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_output("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
        reset = 1'b1;
        tick();
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);

        apply_stimulus(1'b1, 32'h00, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0);
        apply_stimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_BEEF, 1'b0);
        apply_stimulus(1'b1, 32'h11, 32'h0000_0080, 3'b000, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h11, 32'h0,         3'b000, 32'hFFFF_FF80, 1'b0);
        apply_stimulus(1'b0, 32'h11, 32'h0,         3'b100, 32'h0000_0080, 1'b0);
        apply_stimulus(1'b0, 32'h10, 32'h0,         3'b010, 32'hDEAD_80EF, 1'b0);
        apply_stimulus(1'b1, 32'h12, 32'h0000_1234, 3'b001, 32'h0, 1'b0);
        apply_stimulus(1'b0, 32'h12, 32'h0,         3'b001, 32'h0000_1234, 1'b0);
        apply_stimulus(1'b0, 32'h10, 32'h0,         3'b001, 32'hFFFF_80EF, 1'b0);
        apply_stimulus(1'b0, 32'h10, 32'h0,         3'b101, 32'h0000_80EF, 1'b0);
        apply_stimulus(1'b0, 32'h03, 32'h0,         3'b000, 32'hFFFF_FFCA, 1'b0);
        apply_stimulus(1'b0, 32'h02, 32'h0,         3'b100, 32'h0000_00FE, 1'b0);

        apply_stimulus(1'b0, 32'h13,  32'h0,         3'b010, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h11,  32'h0,         3'b001, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h100, 32'h0,         3'b010, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h10,  32'h0,         3'b011, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h10,  32'h0,         3'b110, 32'h0, 1'b1);
        apply_stimulus(1'b1, 32'h102, 32'h1111_1111, 3'b010, 32'h0, 1'b1);
        apply_stimulus(1'b1, 32'h01,  32'h2222_2222, 3'b001, 32'h0, 1'b1);
        apply_stimulus(1'b1, 32'h10,  32'h3333_3333, 3'b100, 32'h0, 1'b1);
        apply_stimulus(1'b0, 32'h00,  32'h0,         3'b010, 32'hCAFE_F00D, 1'b0);
        apply_stimulus(1'b0, 32'h10,  32'h0,         3'b010, 32'h1234_80EF, 1'b0);

        // Response held under backpressure, then released
        rsp_ready = 1'b0;
        send_req(1'b0, 32'h10, 32'h0, 3'b010, 32'h1234_80EF, 1'b0);
        wait_rsp();
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("stall%0d_valid", i), {31'd0, rsp_valid}, 32'd1);
            check_output($sformatf("stall%0d_rdata", i), rsp_rdata, 32'h1234_80EF);
            check_output($sformatf("stall%0d_error", i), {31'd0, rsp_error}, 32'd0);
            check_output($sformatf("stall%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check_output("release_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("release_rdata", rsp_rdata, 32'd0);
        check_output("release_error", {31'd0, rsp_error}, 32'd0);
        check_output("release_req_ready", {31'd0, req_ready}, 32'd1);
        drain();

        // Reset in WAIT aborts the store
        apply_stimulus(1'b1, 32'h20, 32'h1111_2222, 3'b010, 32'h0, 1'b0);
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_AAAA; req_funct3 = 3'b010;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check_output("abort_in_wait", {31'd0, req_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_output("abort_rst_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_output("abort_req_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_output($sformatf("abort_no_rsp%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        apply_stimulus(1'b0, 32'h20, 32'h0, 3'b010, 32'h1111_2222, 1'b0);

        // Zero-wait instance with req_valid held high: one acceptance every 3 cycles
        req_valid0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_write0  = z_write[i];
            req_addr0   = z_addr[i];
            req_wdata0  = 32'hA5A5_0F0F;
            req_funct30 = z_f3[i];
            check_output($sformatf("z%0d_idle_ready", i), {31'd0, req_ready0}, 32'd1);
            tick();
            check_output($sformatf("z%0d_busy_ready", i), {31'd0, req_ready0}, 32'd0);
            check_output($sformatf("z%0d_early_valid", i), {31'd0, rsp_valid0}, 32'd0);
            tick();
            check_output($sformatf("z%0d_valid", i), {31'd0, rsp_valid0}, 32'd1);
            check_output($sformatf("z%0d_rdata", i), rsp_rdata0, z_exp[i]);
            check_output($sformatf("z%0d_error", i), {31'd0, rsp_error0}, 32'd0);
            tick();
        end
        req_valid0 = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
